// File: rtl/midi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : midi_pkg
//  Purpose  : Shared MIDI status/controller constants and the allocator FSM
//             state type.
//  Revision : 1.0  initial release
// ============================================================================
package midi_pkg;

  // Status-byte high nibbles
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;

  // Controller numbers with special meaning
  localparam logic [6:0] CC_SUSTAIN = 7'd64;
  localparam logic [6:0] CC_ALL_OFF = 7'd123;

  // Allocator sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_GAP    = 2'd2,
    ST_ACKW   = 2'd3
  } state_t;

endpackage : midi_pkg
`default_nettype wire

// File: rtl/voice_select.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : voice_select
//  Purpose  : Single-cycle choice of the voice that receives a note-on.
//             Priority: retrigger of a sounding/held voice with the same
//             note, else the oldest free voice, else the oldest voice
//             overall (steal). Also reports whether that voice is gated.
//  Revision : 1.0  initial release
// ============================================================================
module voice_select #(
  parameter int NUM_VOICES = 4
) (
  input  logic [NUM_VOICES-1:0]                         i_gate,
  input  logic [NUM_VOICES-1:0]                         i_held,
  input  logic [NUM_VOICES-1:0][6:0]                    i_note,
  input  logic [NUM_VOICES-1:0][$clog2(NUM_VOICES)-1:0] i_rank,
  input  logic [6:0]                                    i_p1,
  output logic [$clog2(NUM_VOICES)-1:0]                 o_v,
  output logic                                          o_needs_gap
);

  localparam int RW = $clog2(NUM_VOICES);

  logic [NUM_VOICES-1:0] w_match;
  logic [NUM_VOICES-1:0] w_free_top;
  logic [NUM_VOICES-1:0] w_oldest;
  logic [NUM_VOICES-1:0] w_pick;
  logic [NUM_VOICES-1:0] w_onehot;

  // Per-voice candidate flags; ranks form a permutation so the free-top and
  // oldest vectors are at most one-hot
  always_comb begin
    w_match    = '0;
    w_free_top = '0;
    w_oldest   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_match[i]    = (i_note[i] == i_p1) && (i_gate[i] || i_held[i]);
      w_oldest[i]   = (i_rank[i] == RW'(NUM_VOICES - 1));
      w_free_top[i] = ~i_gate[i];
      for (int j = 0; j < NUM_VOICES; j++) begin
        if (!i_gate[j] && (i_rank[j] > i_rank[i])) begin
          w_free_top[i] = 1'b0;
        end
      end
    end
  end

  // Priority between candidate classes, then lowest-index isolate and encode
  always_comb begin
    if (|w_match) begin
      w_pick = w_match;
    end else if (|w_free_top) begin
      w_pick = w_free_top;
    end else begin
      w_pick = w_oldest;
    end
    w_onehot    = w_pick & (~w_pick + 1'b1);
    o_needs_gap = |(w_onehot & i_gate);
    o_v         = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_onehot[i]) begin
        o_v = o_v | RW'(i);
      end
    end
  end

endmodule : voice_select
`default_nettype wire

// File: rtl/midi_voice_allocator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : midi_voice_allocator
//  Purpose  : Polyphonic voice allocator / gate sequencer. Accepts framed
//             MIDI events, assigns note-ons to voices with LRU stealing,
//             forces a gate-low gap on retrigger, handles sustain pedal and
//             all-notes-off.
//  Revision : 1.0  initial release
// ============================================================================
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int GAP_CYCLES = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_evt_valid,
  input  logic [7:0]              i_evt_command,
  input  logic [6:0]              i_evt_param1,
  input  logic [6:0]              i_evt_param2,
  output logic                    o_evt_ack,
  output logic [NUM_VOICES-1:0]   o_voice_gate,
  output logic [7*NUM_VOICES-1:0] o_voice_note,
  output logic [7*NUM_VOICES-1:0] o_voice_velocity,
  output logic                    o_busy
);

  localparam int RW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(GAP_CYCLES + 1);

  state_t                         r_state;
  state_t                         w_state_nxt;

  logic [3:0]                     r_cmd;      // status nibble only (omni)
  logic [6:0]                     r_p1;
  logic [6:0]                     r_p2;

  logic [NUM_VOICES-1:0]          r_gate;
  logic [NUM_VOICES-1:0]          r_held;
  logic [NUM_VOICES-1:0][6:0]     r_note;
  logic [NUM_VOICES-1:0][6:0]     r_vel;
  logic [NUM_VOICES-1:0][RW-1:0]  r_rank;
  logic                           r_sustain;
  logic [CW-1:0]                  r_gap_cnt;
  logic [RW-1:0]                  r_v;
  logic                           r_ack;

  logic [RW-1:0]                  w_sel_v;
  logic                           w_needs_gap;
  logic                           w_is_note_on;
  logic                           w_is_note_off;
  logic                           w_is_sustain;
  logic                           w_is_all_off;

  logic                           w_latch;
  logic                           w_alloc_now;
  logic                           w_alloc_gap;
  logic                           w_note_off;
  logic                           w_sustain;
  logic                           w_all_off;
  logic                           w_gap_done;
  logic                           w_ack_nxt;

  // The channel nibble has no effect on behaviour
  logic                           w_unused_chan;
  assign w_unused_chan = ^i_evt_command[3:0];

  voice_select #(
    .NUM_VOICES (NUM_VOICES)
  ) u_voice_select (
    .i_gate      (r_gate),
    .i_held      (r_held),
    .i_note      (r_note),
    .i_rank      (r_rank),
    .i_p1        (r_p1),
    .o_v         (w_sel_v),
    .o_needs_gap (w_needs_gap)
  );

  assign w_is_note_on  = (r_cmd == NOTE_ON) && (|r_p2);
  assign w_is_note_off = (r_cmd == NOTE_OFF) || ((r_cmd == NOTE_ON) && !(|r_p2));
  assign w_is_sustain  = (r_cmd == CC) && (r_p1 == CC_SUSTAIN);
  assign w_is_all_off  = (r_cmd == CC) && (r_p1 == CC_ALL_OFF);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle action strobes
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_alloc_now = 1'b0;
    w_alloc_gap = 1'b0;
    w_note_off  = 1'b0;
    w_sustain   = 1'b0;
    w_all_off   = 1'b0;
    w_gap_done  = 1'b0;
    w_ack_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_evt_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (w_is_note_on && w_needs_gap) begin
          w_alloc_gap = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_alloc_now = w_is_note_on;
          w_note_off  = w_is_note_off;
          w_sustain   = w_is_sustain;
          w_all_off   = w_is_all_off;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_ACKW;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          w_gap_done  = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_ACKW;
        end
      end
      ST_ACKW: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Event capture; the copy is held until the event completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
      r_p1  <= '0;
      r_p2  <= '0;
    end else if (w_latch) begin
      r_cmd <= i_evt_command[7:4];
      r_p1  <= i_evt_param1;
      r_p2  <= i_evt_param2;
    end
  end

  // Gap countdown and the registered ack pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= w_ack_nxt;
      if (w_alloc_gap) begin
        r_gap_cnt <= CW'(GAP_CYCLES - 1);
      end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  // Per-voice state: gate, note, velocity, held, LRU rank, sustain pedal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate    <= '0;
      r_held    <= '0;
      r_note    <= '0;
      r_vel     <= '0;
      r_sustain <= 1'b0;
      r_v       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_rank[i] <= RW'(i);
      end
    end else begin
      if (w_alloc_now || w_alloc_gap) begin
        r_v             <= w_sel_v;
        r_held[w_sel_v] <= 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (r_rank[i] < r_rank[w_sel_v]) begin
            r_rank[i] <= r_rank[i] + 1'b1;
          end
        end
        r_rank[w_sel_v] <= '0;
      end
      if (w_alloc_now) begin
        r_note[w_sel_v] <= r_p1;
        r_vel[w_sel_v]  <= r_p2;
        r_gate[w_sel_v] <= 1'b1;
      end
      if (w_alloc_gap) begin
        r_gate[w_sel_v] <= 1'b0;
      end
      if (w_gap_done) begin
        r_note[r_v] <= r_p1;
        r_vel[r_v]  <= r_p2;
        r_gate[r_v] <= 1'b1;
      end
      if (w_note_off) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if ((r_note[i] == r_p1) && r_gate[i]) begin
            if (r_sustain) begin
              r_held[i] <= 1'b1;
            end else begin
              r_gate[i] <= 1'b0;
            end
          end
        end
      end
      if (w_sustain) begin
        r_sustain <= r_p2[6];
        // Pedal release drops every voice that was only sounding because of it
        if (r_sustain && !r_p2[6]) begin
          r_gate <= r_gate & ~r_held;
          r_held <= '0;
        end
      end
      if (w_all_off) begin
        r_gate <= '0;
        r_held <= '0;
      end
    end
  end

  assign o_evt_ack        = r_ack;
  assign o_voice_gate     = r_gate;
  assign o_voice_note     = r_note;
  assign o_voice_velocity = r_vel;
  assign o_busy           = (r_state != ST_IDLE);

endmodule : midi_voice_allocator
`default_nettype wire

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Polyphonic voice allocator and gate sequencer sitting between the MIDI framer and the bank of `voice` instances in the MIDI player. It consumes framed MIDI events over a valid/ack handshake and decides which voice plays each note. It prefers free voices, steals the least-recently-allocated voice when none is free, and forces a gate-low gap on retrigger so the ADSR restarts. It also implements sustain-pedal hold and all-notes-off; note-to-frequency conversion stays downstream.

## Interface

Parameters:

- `NUM_VOICES`, default 4: number of voices managed; power of two, 2..16.
- `GAP_CYCLES`, default 512: `clk` cycles the gate is held low before a stolen or retriggered voice is re-gated. Must exceed one SAMPLE_CLK period (≈363 `clk` cycles at 16 MHz).

Ports:

- `clk`  in  1: system clock, 16 MHz.
- `rst_n`  in  1: asynchronous, active-low reset.
- `evt_valid`  in  1: framed MIDI event available; held high until acked.
- `evt_command`  in  8: status byte; the channel nibble is ignored (omni).
- `evt_param1`  in  7: note number or controller number.
- `evt_param2`  in  7: velocity or controller value.
- `evt_ack`  out  1: one-cycle pulse when the event is fully processed.
- `voice_gate`  out  NUM_VOICES: per-voice gate.
- `voice_note`  out  7*NUM_VOICES: flattened per-voice note; voice i occupies bits [7i+6:7i].
- `voice_velocity`  out  7*NUM_VOICES: flattened per-voice velocity, same layout.
- `busy`  out  1: high in every state except IDLE.

## Operation

State registers:
- `gate`, `note`, `velocity`, `held`, and `rank` per voice.
- `rank` has width clog2(NUM_VOICES); rank 0 is the most recently allocated voice.
- `sustain`: a single flag.
- Latched event registers `cmd`, `p1`, `p2`.

Reset values:
- All outputs 0.
- `held` = 0, `sustain` = 0.
- `rank[i]` = i.
- FSM in IDLE.

FSM states and transitions:
- **IDLE**: when `evt_valid` is high, latch the event and go to DECIDE.
- **DECIDE**: classify the latched event and act (see event rules below).
- **GAP**: a counter loads GAP_CYCLES-1 and decrements to 0. On reaching 0, write `note`/`velocity` of voice v, set `gate[v]`=1, pulse ack, and go to ACKW.
- **ACKW**: one dead cycle so the upstream block can drop `evt_valid`; then go to IDLE. An event is never sampled in the cycle that `evt_ack` is high.

Event rules in DECIDE:
- **Note-on** (`cmd[7:4]`=9, p2≠0):
  - Target v is chosen in priority order:
    1. A voice with `note`==p1 and (`gate` or `held`) set. This is a retrigger.
    2. Otherwise, the free voice (`gate`=0) with the highest rank.
    3. Otherwise, the voice with the highest rank overall. This is a steal.
  - Update LRU: every voice with rank < `rank[v]` increments its rank; `rank[v]` becomes 0.
  - Clear `held[v]`.
  - If `gate[v]` was 1, drop `gate[v]` to 0 and go to GAP.
  - Else write `note`/`velocity`, set the gate, pulse ack, and go to ACKW.
- **Note-off** (`cmd[7:4]`=8, or note-on with p2=0):
  - Applies to every voice with `note`==p1 and `gate`=1.
  - If `sustain` is 1, set `held` for those voices; `gate` stays high.
  - Otherwise clear their `gate`.
  - `note` is not cleared. Ack, then ACKW.
- **CC 64** (`cmd[7:4]`=B, p1=64):
  - `sustain` := p2[6].
  - On a 1→0 transition, every voice with `held`=1 gets `gate`:=0 and `held`:=0.
- **CC 123**: all `gate` and `held` cleared; `sustain` unchanged.
- **Any other command or controller**: no state change; ack only.

Priority and selection rules:
- Ties are impossible, because ranks are a permutation of 0..NUM_VOICES-1 at all times.
- Voice selection is combinational over all voices in DECIDE, without iterative scanning.

## Timing

- Event is sampled at IDLE edge T0; DECIDE at T1. Outputs are registered and change at T2.
- Non-gap event: voice outputs update and `evt_ack` is high at T2. IDLE resumes at T3; the next event is sampled no earlier than T3.
- Gap event: `gate[v]` falls at T2 and rises at T2+GAP_CYCLES, coincident with `evt_ack`. `voice_note[v]` keeps the old value until the rise.
- `evt_ack` is exactly one cycle wide and is never asserted outside DECIDE exit or GAP exit.
- `rst_n` low at any point, including mid-GAP, returns to reset values immediately. There is no pending ack after reset.
- `evt_valid` dropping while the block is busy is ignored; the latched copy is processed to completion.

## Structure

- Shared package `midi_pkg` holds:
  - Status nibble constants NOTE_OFF=8, NOTE_ON=9, CC=B.
  - Controller numbers CC_SUSTAIN=64 and CC_ALL_OFF=123.
  - The FSM state enum.
- One sub-module: `voice_select`, purely combinational. It takes `gate`, `held`, `note`, `rank`, and p1, and returns target index v and a `needs_gap` flag.

## Test plan

- **Reset then note-on.** After reset, note-on 60/100. Expect: voice 3 (highest rank) gate=1, note=60, vel=100; ack exactly 2 cycles after valid; ranks become 3→0, others +1.
- **Fill and steal.** Five note-ons 60,62,64,65,67 with no note-offs, NUM_VOICES=4. Expect: the fifth goes to the voice holding 60; that voice's gate is low for exactly 512 cycles, then rises with note=67; ack coincides with the rise.
- **Note-off forms.** Note-on 60, then note-off 60 via 0x80. Expect gate=0, note stays 60. Repeat using note-on with velocity 0: identical result.
- **Sustain hold and release.** CC64=127; note-on 60; note-off 60. Expect gate stays 1 and held=1. Then CC64=0: gate=0 in the ack cycle.
- **Retrigger and all-notes-off.** Re-note-on 62 while 62 is sounding. Expect the same voice, a 512-cycle gap, and no rank change for other voices beyond the LRU rule. Then CC123: all gates 0 at T2.
- **Reset during gap.** Assert `rst_n` low 100 cycles into a gap. Expect all outputs 0 immediately, no ack pulse, and the FSM back in IDLE after release.
